imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
// - Instruction-side front end of the PCPU: a 2^ADDR_W x DATA_W instruction RAM.
// - A host streams a program into the RAM over a valid/ready port.
// - Once the program is loaded, the block releases the core (cpu_reset, cpu_enable, cpu_start).
// - While the core runs, the block serves its fetch port (i_addr -> i_datain).
// - Replaces hand-driven i_datain stimulus: benches and top level load programs instead.
// PARAMETERS
// - ADDR_W   8    instruction address width; DEPTH = 2**ADDR_W words.
// - DATA_W   16   instruction word width.
// PORTS
// - clock       in   1       system clock, all state on rising edge.
// - reset       in   1       asynchronous, active-high; clears all state except RAM contents.
// - load_req    in   1       start a (re)load; sampled in IDLE or RUN only.
// - wr_valid    in   1       host word valid.
// - wr_data     in   DATA_W  host instruction word.
// - wr_last     in   1       qualifies the final word of the program.
// - wr_ready    out  1       block accepts a word this cycle.
// - i_addr      in   ADDR_W  fetch address from the PCPU.
// - i_datain    out  DATA_W  fetched instruction to the PCPU.
// - cpu_reset   out  1       active-high hold of the core.
// - cpu_enable  out  1       core enable.
// - cpu_start   out  1       one-cycle start pulse to the core.
// - load_count  out  ADDR_W+1  words written by the most recent load (0..DEPTH).
// - err_ovf     out  1       sticky: RAM filled before wr_last.
// BEHAVIOUR
// - FSM states: IDLE -> LOAD -> START -> RUN; RUN -> LOAD on load_req.
// - Outputs are Moore decodes of the registered state plus registered counters.
// - Reset (any time, including mid-load):
//   - state=IDLE; write pointer wp=0; load_count=0; err_ovf=0.
//   - wr_ready=0, cpu_reset=1, cpu_enable=0, cpu_start=0, i_datain=0.
//   - RAM is not cleared.
// - Reset has priority over every other input.
// - IDLE:
//   - load_req=1 at an edge -> LOAD next cycle.
//   - On that transition: wp=0, load_count=0, err_ovf=0.
//   - wr_valid is ignored.
// - LOAD:
//   - wr_ready=1; cpu_reset=1; cpu_enable=0.
//   - Beat = wr_valid & wr_ready at an edge: mem[wp]<=wr_data; wp++; load_count++.
//   - wr_valid=0 cycles write nothing; gaps are unlimited.
//   - load_req is ignored in LOAD.
// - End of load:
//   - A beat with wr_last=1 -> START next cycle.
//   - A beat at wp==DEPTH-1 also -> START next cycle (RAM full).
//   - If that full beat has wr_last=0, set err_ovf=1.
//   - wp never wraps; no beat is ever dropped.
// - START (exactly one cycle):
//   - cpu_start=1, cpu_enable=1, cpu_reset=0, wr_ready=0.
//   - Always -> RUN. load_req is ignored in START.
// - RUN:
//   - cpu_enable=1, cpu_reset=0, cpu_start=0, wr_ready=0.
//   - load_req=1 -> LOAD next cycle: cpu_enable=0 and cpu_reset=1 from that cycle.
// - Fetch port:
//   - In RUN and START: i_datain = mem[i_addr], combinational (zero-latency read), for the single-cycle IF stage.
//   - Otherwise i_datain = 0 (NOP).
// - Timing: last beat accepted at edge N -> cpu_start high during cycle N..N+1 -> RUN from edge N+1.
// - Latency load_req -> wr_ready = 1 cycle.
// - load_count saturates at DEPTH (9 bits for ADDR_W=8) and holds until the next load_req.
// TESTING
// - Reset: assert reset asynchronously mid-cycle -> outputs go to reset values immediately, without a clock edge.
// - Load 3 words (16'h1234, 16'h5678, 16'h9abc; last on the third):
//   - load_count=3; cpu_start high exactly one cycle, then cpu_enable=1.
//   - In RUN, i_addr=1 -> i_datain=16'h5678.
// - Back-pressure: same 3 words with wr_valid low 2 cycles between beats -> identical RAM image and load_count=3.
// - Overflow: 256 beats, wr_last=0 -> err_ovf=1, load_count=256, START after beat 256.
// - Reset mid-load after 2 beats -> IDLE, load_count=0, cpu_enable=0. A following 1-word load with last -> load_count=1, RUN.
// - load_req in RUN -> next cycle cpu_enable=0, cpu_reset=1, i_datain=0.
//   - Reload 2 words -> new image fetched at i_addr 0..1.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction RAM front end for the PCPU. A host streams a program in over
// a valid/ready port, then the block releases the core and serves its fetch port.
module imem_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_req,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_datain,
   output logic              cpu_reset,
   output logic              cpu_enable,
   output logic              cpu_start,
   output logic [ADDR_W:0]   load_count,
   output logic              err_ovf
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] LAST_WP  = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      START = 2'd2,
      RUN   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W:0]   wp_q, wp_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              beat;

   logic [DATA_W-1:0] mem [DEPTH];

   assign beat = wr_valid && (state_q == LOAD);

   always_comb begin
      state_d = state_q;
      wp_d    = wp_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, RUN: begin
            if (load_req) begin
               state_d = LOAD;
               wp_d    = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         LOAD: begin
            if (beat) begin
               wp_d  = wp_q + 1'b1;
               cnt_d = (cnt_q == FULL_CNT) ? cnt_q : cnt_q + 1'b1;
               // The last RAM slot ends the load even without wr_last, so
               // the pointer never wraps onto the start of the program.
               if (wr_last || (wp_q == LAST_WP)) begin
                  state_d = START;
               end
               if ((wp_q == LAST_WP) && !wr_last) begin
                  ovf_d = 1'b1;
               end
            end
         end
         START: begin
            state_d = RUN;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         wp_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wp_q    <= wp_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // RAM contents survive reset so a program can outlive a core restart.
   always_ff @(posedge clock) begin
      if (beat) begin
         mem[wp_q[ADDR_W-1:0]] <= wr_data;
      end
   end

   assign wr_ready   = (state_q == LOAD);
   assign cpu_start  = (state_q == START);
   assign cpu_enable = (state_q == START) || (state_q == RUN);
   assign cpu_reset  = !cpu_enable;
   assign load_count = cnt_q;
   assign err_ovf    = ovf_q;

   // Zero-latency fetch for the single-cycle IF stage; NOP while not running.
   assign i_datain = cpu_enable ? mem[i_addr] : '0;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, loads with and without gaps,
// overflow, reset mid-load and reload from RUN.
module tb_imem_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic        load_req;
   logic        wr_valid;
   logic [15:0] wr_data;
   logic        wr_last;
   logic        wr_ready;
   logic [7:0]  i_addr;
   logic [15:0] i_datain;
   logic        cpu_reset;
   logic        cpu_enable;
   logic        cpu_start;
   logic [8:0]  load_count;
   logic        err_ovf;

   int tests_run = 0;
   int tests_failed = 0;

   imem_loader #(.ADDR_W(8), .DATA_W(16)) dut (
      .clock      (clock),
      .reset      (reset),
      .load_req   (load_req),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_last    (wr_last),
      .wr_ready   (wr_ready),
      .i_addr     (i_addr),
      .i_datain   (i_datain),
      .cpu_reset  (cpu_reset),
      .cpu_enable (cpu_enable),
      .cpu_start  (cpu_start),
      .load_count (load_count),
      .err_ovf    (err_ovf)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_load();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic beat(input logic [15:0] d, input logic last, input int gap);
      wr_valid = 1'b1;
      wr_data  = d;
      wr_last  = last;
      tick();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      for (int g = 0; g < gap; g++) tick();
   endtask

   task automatic fetch(input string tag, input logic [7:0] a, input logic [15:0] exp);
      i_addr = a;
      #1;
      chk(tag, 32'(i_datain), 32'(exp));
   endtask

   initial begin
      reset    = 1'b1;
      load_req = 1'b0;
      wr_valid = 1'b0;
      wr_data  = 16'h0;
      wr_last  = 1'b0;
      i_addr   = 8'h0;
      tick();
      tick();
      reset = 1'b0;

      // Reset values
      chk("rst_wr_ready", 32'(wr_ready), 32'h0);
      chk("rst_cpu_reset", 32'(cpu_reset), 32'h1);
      chk("rst_cpu_enable", 32'(cpu_enable), 32'h0);
      chk("rst_cpu_start", 32'(cpu_start), 32'h0);
      chk("rst_i_datain", 32'(i_datain), 32'h0);
      chk("rst_load_count", 32'(load_count), 32'h0);
      chk("rst_err_ovf", 32'(err_ovf), 32'h0);

      // wr_valid in IDLE is ignored
      wr_valid = 1'b1;
      wr_data  = 16'hdead;
      tick();
      wr_valid = 1'b0;
      chk("idle_ignore_cnt", 32'(load_count), 32'h0);
      chk("idle_ignore_ready", 32'(wr_ready), 32'h0);

      // Basic 3-word load
      start_load();
      chk("load_ready", 32'(wr_ready), 32'h1);
      chk("load_cpu_reset", 32'(cpu_reset), 32'h1);
      beat(16'h1234, 1'b0, 0);
      beat(16'h5678, 1'b0, 0);
      chk("load_mid_start", 32'(cpu_start), 32'h0);
      beat(16'h9abc, 1'b1, 0);
      chk("start_pulse", 32'(cpu_start), 32'h1);
      chk("start_enable", 32'(cpu_enable), 32'h1);
      chk("start_cpu_reset", 32'(cpu_reset), 32'h0);
      chk("start_ready", 32'(wr_ready), 32'h0);
      chk("load3_count", 32'(load_count), 32'h3);
      chk("load3_ovf", 32'(err_ovf), 32'h0);
      fetch("start_fetch0", 8'd0, 16'h1234);
      load_req = 1'b1;       // ignored in START
      tick();
      load_req = 1'b0;
      chk("run_start_low", 32'(cpu_start), 32'h0);
      chk("run_enable", 32'(cpu_enable), 32'h1);
      chk("run_ready", 32'(wr_ready), 32'h0);
      fetch("run_fetch1", 8'd1, 16'h5678);
      fetch("run_fetch2", 8'd2, 16'h9abc);
      tick();
      chk("run_hold_enable", 32'(cpu_enable), 32'h1);

      // Reload with back-pressure gaps
      start_load();
      chk("reload_enable", 32'(cpu_enable), 32'h0);
      chk("reload_cpu_reset", 32'(cpu_reset), 32'h1);
      chk("reload_idatain", 32'(i_datain), 32'h0);
      chk("reload_count_clr", 32'(load_count), 32'h0);
      beat(16'h1234, 1'b0, 2);
      chk("gap_count", 32'(load_count), 32'h1);
      chk("gap_ready", 32'(wr_ready), 32'h1);
      beat(16'h5678, 1'b0, 2);
      beat(16'h9abc, 1'b1, 0);
      chk("gap_start", 32'(cpu_start), 32'h1);
      chk("gap_count3", 32'(load_count), 32'h3);
      tick();
      fetch("gap_fetch0", 8'd0, 16'h1234);
      fetch("gap_fetch1", 8'd1, 16'h5678);
      fetch("gap_fetch2", 8'd2, 16'h9abc);

      // Overflow: 256 beats with no wr_last
      start_load();
      for (int i = 0; i < 255; i++) beat(16'ha000 + 16'(i), 1'b0, 0);
      chk("ovf_pre_ready", 32'(wr_ready), 32'h1);
      chk("ovf_pre_flag", 32'(err_ovf), 32'h0);
      chk("ovf_pre_count", 32'(load_count), 32'd255);
      beat(16'ha0ff, 1'b0, 0);
      chk("ovf_start", 32'(cpu_start), 32'h1);
      chk("ovf_flag", 32'(err_ovf), 32'h1);
      chk("ovf_count", 32'(load_count), 32'd256);
      tick();
      chk("ovf_run", 32'(cpu_enable), 32'h1);
      chk("ovf_sticky", 32'(err_ovf), 32'h1);
      fetch("ovf_fetch0", 8'd0, 16'ha000);
      fetch("ovf_fetch17", 8'd17, 16'ha011);
      fetch("ovf_fetch255", 8'd255, 16'ha0ff);

      // Asynchronous reset mid-load after 2 beats
      start_load();
      beat(16'hc000, 1'b0, 0);
      beat(16'hc001, 1'b0, 0);
      chk("mid_count2", 32'(load_count), 32'h2);
      #3;
      reset = 1'b1;
      #1;
      chk("async_ready", 32'(wr_ready), 32'h0);
      chk("async_count", 32'(load_count), 32'h0);
      chk("async_enable", 32'(cpu_enable), 32'h0);
      chk("async_cpu_reset", 32'(cpu_reset), 32'h1);
      chk("async_ovf", 32'(err_ovf), 32'h0);
      tick();
      reset = 1'b0;
      chk("after_rst_ready", 32'(wr_ready), 32'h0);
      start_load();
      beat(16'hbeef, 1'b1, 0);
      chk("one_count", 32'(load_count), 32'h1);
      chk("one_start", 32'(cpu_start), 32'h1);
      tick();
      chk("one_run", 32'(cpu_enable), 32'h1);
      fetch("one_fetch0", 8'd0, 16'hbeef);
      fetch("one_fetch1", 8'd1, 16'hc001);
      fetch("one_fetch2_kept", 8'd2, 16'ha002);

      // Async reset while running drops the core immediately
      tick();
      #3;
      reset = 1'b1;
      #1;
      chk("run_async_enable", 32'(cpu_enable), 32'h0);
      chk("run_async_idatain", 32'(i_datain), 32'h0);
      tick();
      reset = 1'b0;

      // Load, then reload from RUN
      start_load();
      beat(16'h0f0f, 1'b1, 0);
      tick();
      i_addr = 8'd0;
      start_load();
      chk("rl_enable", 32'(cpu_enable), 32'h0);
      chk("rl_cpu_reset", 32'(cpu_reset), 32'h1);
      chk("rl_idatain", 32'(i_datain), 32'h0);
      beat(16'h1111, 1'b0, 1);
      beat(16'h2222, 1'b1, 0);
      chk("rl_count", 32'(load_count), 32'h2);
      tick();
      fetch("rl_fetch0", 8'd0, 16'h1111);
      fetch("rl_fetch1", 8'd1, 16'h2222);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
